pos_stream_decoder: RTL and testbench

- Inverse of the 8-bit priority encoder path: rebuilds a bit vector from a stream of bit-position beats.
- The upstream iterative encoder emits set-bit positions lowest-first, one per beat; this block ORs their one-hot decodes into a frame vector.
- Emits the completed vector, beat count and ordering-error flag over a valid/ready output.
- Sits at the receive end of the position-stream link, feeding downstream consumers that expect the original din-style vector.

---
 rtl/pos_stream_decoder.sv | 144 ++++++++++++++
 tb/tb_pos_stream_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_stream_decoder.sv
// Rebuilds a bit vector from a lowest-first stream of set-bit position beats.
// Optional macro POS_STREAM_ORDER_CHECK_EN flags beats whose position is not strictly ascending.
module pos_stream_decoder #(
    parameter int WIDTH = 8,
    parameter int POS_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POS_W-1:0] in_pos,
    input  logic             in_zero,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic [POS_W:0]   out_count,
    output logic             out_err
);

    typedef enum logic {
        S_ACC,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_acc_vec;
    logic [POS_W:0]   r_acc_cnt;
    logic             r_acc_err;

    logic [WIDTH-1:0] r_out_vec;
    logic [POS_W:0]   r_out_cnt;
    logic             r_out_err;

    logic             w_accept;
    logic [WIDTH-1:0] w_beat_vec;
    logic [WIDTH-1:0] w_frame_vec;
    logic [POS_W:0]   w_frame_cnt;
    logic             w_order_err;
    logic             w_frame_err;

`ifdef POS_STREAM_ORDER_CHECK_EN
    logic [POS_W-1:0] r_last_pos;
    logic             r_first;

    // Zero beats carry no position, so they neither set nor consult the ordering history.
    assign w_order_err = !r_first && !in_zero && (in_pos <= r_last_pos);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_pos <= '0;
            r_first    <= 1'b1;
        end else if (w_accept) begin
            if (in_last) begin
                r_last_pos <= '0;
                r_first    <= 1'b1;
            end else if (!in_zero) begin
                r_last_pos <= in_pos;
                r_first    <= 1'b0;
            end
        end
    end
`else
    assign w_order_err = 1'b0;
`endif

    assign in_ready  = (r_state == S_ACC) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_HOLD);
    assign out_vec   = r_out_vec;
    assign out_count = r_out_cnt;
    assign out_err   = r_out_err;

    always_comb begin
        w_beat_vec = '0;
        if (!in_zero) begin
            w_beat_vec[in_pos] = 1'b1;
        end
        w_frame_vec = r_acc_vec | w_beat_vec;
        w_frame_cnt = r_acc_cnt;
        if (!in_zero && (r_acc_cnt != '1)) begin
            w_frame_cnt = r_acc_cnt + 1'b1;
        end
        w_frame_err = r_acc_err | (in_zero & ~in_last) | w_order_err;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACC: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = (w_accept && in_last) ? S_HOLD : S_ACC;
                end
            end
            default: w_state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc_vec <= '0;
            r_acc_cnt <= '0;
            r_acc_err <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc_vec <= '0;
                r_acc_cnt <= '0;
                r_acc_err <= 1'b0;
            end else begin
                r_acc_vec <= w_frame_vec;
                r_acc_cnt <= w_frame_cnt;
                r_acc_err <= w_frame_err;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_vec <= '0;
            r_out_cnt <= '0;
            r_out_err <= 1'b0;
        end else if (w_accept && in_last) begin
            r_out_vec <= w_frame_vec;
            r_out_cnt <= w_frame_cnt;
            r_out_err <= w_frame_err;
        end
    end

endmodule

// File: tb/tb_pos_stream_decoder.sv
// Scoreboard bench for pos_stream_decoder: directed cases, exhaustive 256-vector round trip, random frames.
module tb_pos_stream_decoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_pos = '0;
    logic       in_zero = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_vec;
    logic [3:0] out_count;
    logic       out_err;

    bit rand_ready = 1'b0;
    bit bubbles    = 1'b0;
    int tests = 0;
    int fails = 0;

`ifdef POS_STREAM_ORDER_CHECK_EN
    localparam bit ORDER = 1'b1;
`else
    localparam bit ORDER = 1'b0;
`endif

    typedef struct {
        logic [7:0] vec;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   frame[$];   // position per beat; -1 marks an in_zero beat

    pos_stream_decoder #(.WIDTH(8), .POS_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos),
        .in_zero(in_zero), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_count(out_count), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: vector is the OR of the positions, count is the number of positional beats.
    function automatic exp_t model();
        exp_t e;
        int   n = 0;
        int   prev = -1;
        e.vec = '0;
        e.err = 1'b0;
        for (int i = 0; i < frame.size(); i++) begin
            if (frame[i] < 0) begin
                if (i != frame.size() - 1) e.err = 1'b1;
            end else begin
                e.vec = e.vec | (8'd1 << frame[i]);
                n++;
                if (ORDER && prev >= 0 && frame[i] <= prev) e.err = 1'b1;
                prev = frame[i];
            end
        end
        e.cnt = 4'((n > 15) ? 15 : n);
        return e;
    endfunction

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic drive_beat(input int p, input bit last);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_zero  = (p < 0);
        in_pos   = (p < 0) ? 3'($urandom) : 3'(p);
        in_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 1000) begin
                fails++;
                $display("FAIL beat_accept_timeout: got in_ready=0 expected 1 within 1000 cycles");
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1, "beat never accepted");
            end
        end
        in_valid = 1'b0;
        if (bubbles && $urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame();
        sb.push_back(model());
        for (int i = 0; i < frame.size(); i++) begin
            drive_beat(frame[i], i == frame.size() - 1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops on every output handshake, and checks stability while held off.
    initial begin
        bit         prev_hold = 1'b0;
        logic [7:0] prev_vec;
        logic [3:0] prev_cnt;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_stable", {20'd0, out_count, out_vec}, {20'd0, prev_cnt, prev_vec});
                end
                prev_hold = out_valid && !out_ready;
                prev_vec  = out_vec;
                prev_cnt  = out_count;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_vec", 32'(out_vec), 32'(e.vec));
                        check("out_count", 32'(out_count), 32'(e.cnt));
                        check("out_err", 32'(out_err), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_vec", 32'(out_vec), 32'd0);
        check("reset_out_count", 32'(out_count), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Ascending frame with one-cycle latency to out_valid
        frame = '{0, 3, 7};
        send_frame();
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_vec", 32'(out_vec), 32'h89);

        frame = '{-1};    send_frame();
        frame = '{4, 2};  send_frame();
        frame = '{-1, 3}; send_frame();
        frame = '{0, 1, 2, 3, 4, 5, 6, 7}; send_frame();
        frame = '{6, 6};  send_frame();
        wait_drain();

        // Back-pressure: second frame stalls, then is taken with no valid gap
        out_ready = 1'b0;
        frame = '{5};
        send_frame();
        frame = '{1};
        sb.push_back(model());
        in_valid = 1'b1; in_zero = 1'b0; in_pos = 3'd1; in_last = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_vec_held", 32'(out_vec), 32'h20);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_no_gap_valid", 32'(out_valid), 32'd1);
        check("bp_new_vec", 32'(out_vec), 32'h02);
        wait_drain();

        // Reset mid-frame discards partial accumulation
        drive_beat(1, 1'b0);
        drive_beat(4, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_vec", 32'(out_vec), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        frame = '{2};
        send_frame();
        wait_drain();

        // Exhaustive round trip with random back-pressure and bubbles
        rand_ready = 1'b1;
        bubbles    = 1'b1;
        for (int v = 0; v < 256; v++) begin
            frame.delete();
            if (v == 0) frame.push_back(-1);
            for (int b = 0; b < 8; b++) begin
                if (v[b]) frame.push_back(b);
            end
            send_frame();
        end

        // Random frames: arbitrary order, duplicates, occasional misuse, saturating lengths
        for (int f = 0; f < 300; f++) begin
            int n;
            frame.delete();
            n = (f % 50 == 49) ? 17 + $urandom_range(3) : 1 + $urandom_range(7);
            for (int i = 0; i < n; i++) frame.push_back(int'($urandom_range(7)));
            if ($urandom_range(9) == 0 && n > 1) frame[$urandom_range(n - 2)] = -1;
            send_frame();
        end

        rand_ready = 1'b0;
        #1;
        out_ready = 1'b1;
        wait_drain();
        repeat (2) @(posedge clk);
        finish_run();
    end

endmodule
